reorder_buffer: RTL and testbench
=================================

Name: reorder_buffer

Overview:
- In-order commit buffer sitting between rename/issue and the RAT writeback port.
- Records each issued instruction by the tag the RAT handed out, collects out-of-order execution results by tag, and retires the oldest completed entry into the RAT's writeback interface (value, reg number, tag), one per cycle.
- Discards speculative entries younger than a taken branch, using the same branch tag semantics as the RAT.

Parameters:
- SIZE, 16, number of entries; power of two, 2..32; SIZE <= 2^(TAG_W-1).
- TAG_W, 6, tag width; matches RAT tag width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- IN_issueValid  in  1  instruction issued this cycle; accepted only if OUT_full=0.
- IN_issueRegNm  in  5  destination register (0 = none).
- IN_issueTag  in  TAG_W  tag assigned by the RAT to this instruction.
- IN_resValid  in  1  execution result valid.
- IN_resTag  in  TAG_W  tag of the result.
- IN_resValue  in  32  result value.
- IN_branchTaken  in  1  flush request.
- IN_branchTag  in  TAG_W  tag of the branch; that entry and all older entries survive.
- OUT_full  out  1  count == SIZE; issue must stall.
- OUT_wbValid  out  1  commit pulse to RAT.
- OUT_wbRegNm  out  5  committed destination register.
- OUT_wbRegTag  out  TAG_W  committed tag.
- OUT_wbResult  out  32  committed value.

Behaviour:
State:
- Per entry: valid, done, regNm, tag, value.
- headTag (TAG_W): tag of the oldest entry.
- count (0..SIZE).
- Entry index is always tag[log2(SIZE)-1:0].

Reset (rst=0, asynchronous):
- All valid/done = 0; headTag = 0; count = 0.
- All outputs 0; OUT_full = 0.
- Reset mid-operation drops every entry and any pending commit immediately.

Issue:
- On a clock edge with IN_issueValid=1 and OUT_full=0, the entry at IN_issueTag's index gets valid=1, done=0, regNm, tag.
- IN_issueTag must equal headTag+count (mod 2^TAG_W); the bench checks this with an assertion.
- OUT_full is registered state; there is no same-cycle bypass from a commit. When full, issue is ignored even if a commit occurs that cycle.

Result:
- With IN_resValid=1, the entry at IN_resTag's index is updated (done=1, value=IN_resValue) only if it is valid and its stored tag == IN_resTag.
- Stale, unknown or already-done tags are ignored.

Commit:
- Each cycle, if the head entry is valid and done (state before the edge), the ROB on that edge:
  - drives OUT_wbValid=1 with regNm/tag/value;
  - clears the entry;
  - sets headTag+1 (wraps mod 2^TAG_W) and count-1.
- Otherwise OUT_wbValid=0.
- Outputs are registered. A result accepted at edge N commits at edge N+1 at the earliest, if it is at the head.
- Register 0 entries commit normally with OUT_wbValid=1; the RAT ignores them.

Branch (IN_branchTaken=1):
- age(t) = (t - headTag) mod 2^TAG_W.
- Every entry with age > age(IN_branchTag) is invalidated; count = age(IN_branchTag)+1.
- No commit and no issue that cycle (OUT_wbValid=0), because the RAT ignores writebacks during a branch.
- A result in the same cycle is accepted only for a surviving tag.
- If age(IN_branchTag) >= count, the flush is a no-op for the entries: nothing is invalidated and count is unchanged. OUT_wbValid is still 0 and issue is still ignored that cycle.

Simultaneous events:
- Issue + commit in the same cycle: count unchanged.
- Result + commit of a different entry in the same cycle: both take effect.

Wrap-around:
- Tags wrap at 2^TAG_W; indices wrap at SIZE.
- Age arithmetic is modulo 2^TAG_W.

Test Plan:
1. Reset, issue tags 0,1,2 (regs 5,6,7), results arrive in order 2,0,1 with values 0x22,0x00,0x11 -> OUT_wbValid pulses for tag 0 (reg5, 0x00), then tags 1 and 2 on consecutive cycles, in order 0,1,2; no commit before tag 0's result.
2. Issue 16 entries with no results -> OUT_full=1. A 17th issue is ignored (count stays 16). Result for tag 0 -> commit tag 0 -> OUT_full=0 next cycle.
3. Issue tags 0..5, result tags 4,5, IN_branchTaken with IN_branchTag=3 -> tags 4,5 dropped, count=4. A late result for tag 4 is ignored. Next issue uses tag 4, and its own result commits tag 4 with the new value.
4. Run 70 issue/complete/commit cycles so headTag wraps 63->0 -> commits continue in order; tag 63 commits, then tag 0, with correct values.
5. Assert rst low while 3 entries are pending and a commit is due -> OUT_wbValid=0 immediately, OUT_full=0. After release, first issue tag 0 behaves as in scenario 1.
6. Result for a never-issued tag 9 and a duplicate result for an already-done tag -> no state change, no spurious OUT_wbValid.

Source files
------------

// File: rtl/reorder_buffer.sv
// reorder_buffer: in-order commit buffer, tag-indexed entries, out-of-order results, branch flush.
module reorder_buffer #(
   parameter int SIZE  = 16,
   parameter int TAG_W = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             IN_issueValid,
   input  logic [4:0]       IN_issueRegNm,
   input  logic [TAG_W-1:0] IN_issueTag,
   input  logic             IN_resValid,
   input  logic [TAG_W-1:0] IN_resTag,
   input  logic [31:0]      IN_resValue,
   input  logic             IN_branchTaken,
   input  logic [TAG_W-1:0] IN_branchTag,
   output logic             OUT_full,
   output logic             OUT_wbValid,
   output logic [4:0]       OUT_wbRegNm,
   output logic [TAG_W-1:0] OUT_wbRegTag,
   output logic [31:0]      OUT_wbResult
);
   localparam int IW = $clog2(SIZE);
   logic [SIZE-1:0]  valid, done, kill, com_m, iss_m, res_m;
   logic [4:0]       reg_nm [SIZE];
   logic [TAG_W-1:0] tag_q [SIZE];
   logic [31:0]      value [SIZE];
   logic [TAG_W-1:0] head_tag, count, br_age, res_age;
   logic [IW-1:0]    head_idx, res_idx, iss_idx;
   logic             commit, issue, flush, res_ok;
   assign head_idx = head_tag[IW-1:0];
   assign res_idx  = IN_resTag[IW-1:0];
   assign iss_idx  = IN_issueTag[IW-1:0];
   assign br_age   = IN_branchTag - head_tag;
   assign res_age  = IN_resTag - head_tag;
   assign OUT_full = count == TAG_W'(SIZE);
   // a branch older than count trims the window; otherwise it only blocks commit/issue
   assign flush  = IN_branchTaken && br_age < count;
   assign commit = !IN_branchTaken && valid[head_idx] && done[head_idx];
   assign issue  = IN_issueValid && !OUT_full && !IN_branchTaken;
   assign res_ok = IN_resValid && valid[res_idx] && !done[res_idx] && tag_q[res_idx] == IN_resTag
                   && !(flush && res_age > br_age);
   assign com_m = SIZE'(commit) << head_idx;
   assign iss_m = SIZE'(issue) << iss_idx;
   assign res_m = SIZE'(res_ok) << res_idx;
   always_comb begin
      kill = '0;
      for (int i = 0; i < SIZE; i++)
         kill[i] = flush && valid[i] && TAG_W'(tag_q[i] - head_tag) > br_age;
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid        <= '0;
         done         <= '0;
         head_tag     <= '0;
         count        <= '0;
         OUT_wbValid  <= 1'b0;
         OUT_wbRegNm  <= '0;
         OUT_wbRegTag <= '0;
         OUT_wbResult <= '0;
      end else begin
         OUT_wbValid <= commit;
         if (commit) begin
            OUT_wbRegNm  <= reg_nm[head_idx];
            OUT_wbRegTag <= tag_q[head_idx];
            OUT_wbResult <= value[head_idx];
            head_tag     <= head_tag + TAG_W'(1);
         end
         count <= flush ? br_age + TAG_W'(1) : count + TAG_W'(issue) - TAG_W'(commit);
         valid <= (valid & ~kill & ~com_m) | iss_m;
         done  <= (done & ~kill & ~com_m & ~iss_m) | res_m;
      end
   end
   always_ff @(posedge clk) begin
      if (issue) begin
         reg_nm[iss_idx] <= IN_issueRegNm;
         tag_q[iss_idx]  <= IN_issueTag;
      end
      if (res_ok) value[res_idx] <= IN_resValue;
   end
endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: queue-based reference model, per-cycle compare, directed plus random scenarios.
module tb_reorder_buffer;
   localparam int SIZE = 16;
   localparam int TW   = 6;
   logic          clk = 0, rst = 0;
   logic          IN_issueValid = 0, IN_resValid = 0, IN_branchTaken = 0;
   logic [4:0]    IN_issueRegNm = 0;
   logic [TW-1:0] IN_issueTag = 0, IN_resTag = 0, IN_branchTag = 0;
   logic [31:0]   IN_resValue = 0;
   logic          OUT_full, OUT_wbValid;
   logic [4:0]    OUT_wbRegNm;
   logic [TW-1:0] OUT_wbRegTag;
   logic [31:0]   OUT_wbResult;
   always #5 clk = ~clk;
   reorder_buffer #(.SIZE(SIZE), .TAG_W(TW)) dut (
      .clk(clk), .rst(rst),
      .IN_issueValid(IN_issueValid), .IN_issueRegNm(IN_issueRegNm), .IN_issueTag(IN_issueTag),
      .IN_resValid(IN_resValid), .IN_resTag(IN_resTag), .IN_resValue(IN_resValue),
      .IN_branchTaken(IN_branchTaken), .IN_branchTag(IN_branchTag),
      .OUT_full(OUT_full), .OUT_wbValid(OUT_wbValid), .OUT_wbRegNm(OUT_wbRegNm),
      .OUT_wbRegTag(OUT_wbRegTag), .OUT_wbResult(OUT_wbResult)
   );
   typedef struct {logic [TW-1:0] tag; logic [4:0] rg; bit done; logic [31:0] val;} ent_t;
   typedef struct {logic [TW-1:0] tag; logic [4:0] rg; logic [31:0] val; int cyc;} wb_t;
   ent_t          mq[$];
   wb_t           wlog[$];
   logic [TW-1:0] mhead = 0, ewb_tag = 0;
   logic          ewb_v = 0, efull = 0;
   logic [4:0]    ewb_rg = 0;
   logic [31:0]   ewb_val = 0;
   int            checks = 0, failures = 0, cyc = 0;
   // model: the ROB is an age-ordered queue, oldest at the front
   always @(posedge clk or negedge rst) begin
      int n, lim, a;
      bit com;
      ent_t e;
      if (!rst) begin
         mq.delete();
         mhead = 0; ewb_v = 0; ewb_rg = 0; ewb_tag = 0; ewb_val = 0; efull = 0;
      end else begin
         n = mq.size(); lim = n; com = 0; ewb_v = 0;
         if (IN_issueValid && !IN_branchTaken && n < SIZE)
            assert (IN_issueTag == TW'(mhead + TW'(n))) else $error("issue tag out of sequence");
         if (IN_branchTaken) begin
            a = int'(TW'(IN_branchTag - mhead));
            if (a < n) lim = a + 1;
         end else com = n > 0 && mq[0].done;
         if (IN_resValid)
            for (int i = 0; i < lim; i++)
               if (mq[i].tag == IN_resTag && !mq[i].done) begin
                  e = mq[i]; e.done = 1; e.val = IN_resValue; mq[i] = e;
               end
         while (mq.size() > lim) void'(mq.pop_back());
         if (com) begin
            e = mq.pop_front();
            ewb_v = 1; ewb_rg = e.rg; ewb_tag = e.tag; ewb_val = e.val;
            mhead = mhead + TW'(1);
         end
         if (IN_issueValid && !IN_branchTaken && n < SIZE)
            mq.push_back('{tag: IN_issueTag, rg: IN_issueRegNm, done: 1'b0, val: 32'd0});
         efull = mq.size() == SIZE;
      end
   end
   always @(negedge clk) begin
      cyc++;
      checks++;
      if (OUT_wbValid !== ewb_v || OUT_full !== efull) begin
         failures++;
         $display("FAIL ctrl cyc=%0d got wbValid=%b full=%b want wbValid=%b full=%b",
                  cyc, OUT_wbValid, OUT_full, ewb_v, efull);
      end
      if (ewb_v) begin
         checks++;
         if ({OUT_wbRegNm, OUT_wbRegTag, OUT_wbResult} !== {ewb_rg, ewb_tag, ewb_val}) begin
            failures++;
            $display("FAIL wbdata cyc=%0d got reg=%0d tag=%0d val=%h want reg=%0d tag=%0d val=%h",
                     cyc, OUT_wbRegNm, OUT_wbRegTag, OUT_wbResult, ewb_rg, ewb_tag, ewb_val);
         end
      end
      if (OUT_wbValid) wlog.push_back('{tag: OUT_wbRegTag, rg: OUT_wbRegNm, val: OUT_wbResult, cyc: cyc});
   end
   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%0h want=%0h", nm, act, exp);
      end
   endtask
   task automatic drive(bit iv, logic [4:0] rg, bit rv, logic [TW-1:0] rt, logic [31:0] rval,
                        bit br, logic [TW-1:0] bt);
      IN_issueValid = iv; IN_issueRegNm = rg; IN_issueTag = mhead + TW'(mq.size());
      IN_resValid = rv; IN_resTag = rt; IN_resValue = rval;
      IN_branchTaken = br; IN_branchTag = bt;
      @(negedge clk);
      #1;
      IN_issueValid = 0; IN_resValid = 0; IN_branchTaken = 0;
   endtask
   task automatic iss(logic [4:0] rg); drive(1, rg, 0, 0, 0, 0, 0); endtask
   task automatic res(logic [TW-1:0] t, logic [31:0] v); drive(0, 0, 1, t, v, 0, 0); endtask
   task automatic brn(logic [TW-1:0] t); drive(0, 0, 0, 0, 0, 1, t); endtask
   task automatic idle(int n); for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0); endtask
   task automatic do_reset();
      rst = 0;
      @(negedge clk);
      #1;
      chk("rst_wbValid", 64'(OUT_wbValid), 0);
      chk("rst_full", 64'(OUT_full), 0);
      @(negedge clk);
      #1;
      rst = 1;
      wlog.delete();
   endtask
   task automatic rand_cyc(bit allow_br);
      logic [TW-1:0] rt;
      rt = (mq.size() > 0 && $urandom_range(0, 2) != 0) ? mq[$urandom_range(0, mq.size() - 1)].tag : TW'($urandom);
      drive($urandom_range(0, 3) != 0, 5'($urandom), $urandom_range(0, 3) != 0, rt, $urandom,
            allow_br && $urandom_range(0, 9) == 0, mhead + TW'($urandom_range(0, 20)));
   endtask
   task automatic scen1();
      iss(5); iss(6); iss(7);
      res(2, 32'h22);
      idle(2);
      chk("s1_no_early_commit", 64'(wlog.size()), 0);
      res(0, 32'h00);
      res(1, 32'h11);
      idle(3);
      chk("s1_commits", 64'(wlog.size()), 3);
      if (wlog.size() == 3) begin
         chk("s1_tag0", 64'(wlog[0].tag), 0);
         chk("s1_reg0", 64'(wlog[0].rg), 5);
         chk("s1_val0", 64'(wlog[0].val), 0);
         chk("s1_tag1", 64'(wlog[1].tag), 1);
         chk("s1_val1", 64'(wlog[1].val), 32'h11);
         chk("s1_tag2", 64'(wlog[2].tag), 2);
         chk("s1_reg2", 64'(wlog[2].rg), 7);
         chk("s1_val2", 64'(wlog[2].val), 32'h22);
         chk("s1_consec", 64'(wlog[2].cyc - wlog[0].cyc), 2);
      end
   endtask
   initial begin
      do_reset();
      scen1();
      do_reset();
      for (int i = 0; i < SIZE; i++) iss(5'(i + 1));
      chk("s2_full", 64'(OUT_full), 1);
      chk("s2_model_count", 64'(mq.size()), 16);
      iss(20);
      chk("s2_17th_ignored", 64'(mq.size()), 16);
      res(0, 32'hAB);
      chk("s2_full_before_commit", 64'(OUT_full), 1);
      iss(21);
      chk("s2_full_after_commit", 64'(OUT_full), 0);
      chk("s2_issue_while_full", 64'(mq.size()), 15);
      chk("s2_commit_val", 64'(wlog.size() == 1 ? wlog[0].val : 32'hDEAD), 32'hAB);
      for (int t = 1; t < SIZE; t++) res(TW'(t), 32'(t * 3));
      idle(3);
      chk("s2_drained", 64'(wlog.size()), 16);
      do_reset();
      for (int i = 0; i < 6; i++) iss(5'(i + 1));
      res(4, 32'h40);
      res(5, 32'h50);
      brn(3);
      chk("s3_count", 64'(mq.size()), 4);
      res(4, 32'h99);
      chk("s3_next_tag", 64'(TW'(mhead + TW'(mq.size()))), 4);
      iss(9);
      res(4, 32'h44);
      for (int t = 0; t < 4; t++) res(TW'(t), 32'(t));
      idle(3);
      chk("s3_commits", 64'(wlog.size()), 5);
      if (wlog.size() == 5) begin
         chk("s3_tag4", 64'(wlog[4].tag), 4);
         chk("s3_reg4", 64'(wlog[4].rg), 9);
         chk("s3_val4", 64'(wlog[4].val), 32'h44);
      end
      do_reset();
      for (int k = 0; k < 1000 && wlog.size() < 70; k++) rand_cyc(0);
      chk("s4_progress", 64'(wlog.size() >= 70), 1);
      if (wlog.size() >= 70) begin
         chk("s4_tag63", 64'(wlog[63].tag), 63);
         chk("s4_wrap_tag0", 64'(wlog[64].tag), 0);
      end
      for (int k = 0; k < 400; k++) rand_cyc(1);
      do_reset();
      iss(1); iss(2); iss(3);
      res(0, 32'h5);
      res(1, 32'h6);
      chk("s5_commit_pending", 64'(OUT_wbValid), 1);
      rst = 0;
      #1;
      chk("s5_async_wb", 64'(OUT_wbValid), 0);
      chk("s5_async_full", 64'(OUT_full), 0);
      @(negedge clk);
      #1;
      rst = 1;
      wlog.delete();
      scen1();
      do_reset();
      iss(1); iss(2);
      res(1, 32'h77);
      res(1, 32'h88);
      res(9, 32'h99);
      idle(2);
      chk("s6_no_spurious", 64'(wlog.size()), 0);
      res(0, 32'h66);
      idle(3);
      chk("s6_commits", 64'(wlog.size()), 2);
      if (wlog.size() == 2) begin
         chk("s6_val0", 64'(wlog[0].val), 32'h66);
         chk("s6_dup_ignored", 64'(wlog[1].val), 32'h77);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end
endmodule
